ram_scan_reader: RTL and testbench

- Read-side engine for the 32x4 on-chip RAM, the counterpart of the switch-driven write path.
- Steps a read address through all 32 locations at a programmable pace and absorbs the RAM's synchronous read latency.
- Presents a stable address/data pair for the HEX display logic.
- Re-reads the displayed location when the write port updates it, so the display never shows stale data.

---
 rtl/mem_pkg.sv | 18 +
 rtl/tick_gen.sv | 28 ++
 rtl/ram_scan_reader.sv | 130 +++++++++++++
 tb/tb_ram_scan_reader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default widths for the 32x4 on-chip RAM and the
// blocks that read or write it.
package mem_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // Read-scan sequencer states: present address, wait out RAM latency, hold display.
  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    SHOW
  } scan_state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running pace divider: emits a one-cycle tick every TICK_DIV enabled
// cycles and holds its count while disabled.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..TICK_DIV-1 while enabled, freeze otherwise.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/ram_scan_reader.sv
// Read-side scan engine for the 32x4 RAM: steps the read address at a
// programmable pace, absorbs the synchronous read latency, and keeps the
// displayed address/data pair fresh when the write port hits it.
module ram_scan_reader #(
  parameter int ADDR_W   = mem_pkg::ADDR_W,
  parameter int DATA_W   = mem_pkg::DATA_W,
  parameter int TICK_DIV = 50_000_000,
  parameter int RD_LAT   = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [DATA_W-1:0] cur_data,
  output logic              cur_valid,
  output logic              wrap
);

  import mem_pkg::*;

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  scan_state_t      state;
  scan_state_t      state_nxt;
  logic             tick;
  logic             capture;
  logic             advance;
  logic             pend;
  logic             snoop_hit;
  logic             cur_hit;
  logic [LAT_W-1:0] lat;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .CLOCK_50(CLOCK_50),
    .reset_n (reset_n),
    .en      (en),
    .tick    (tick)
  );

  // A write landing on the in-flight address may be missed by the read
  // (RAM returns old data on collision), so it must trigger a re-read.
  assign snoop_hit = (state != SHOW) && wr_en && (wr_addr == rd_addr);
  assign cur_hit   = wr_en && (wr_addr == cur_addr);

  // Next-state and datapath strobes; tick beats refresh since the address is moving anyway.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if ((lat == LAT_W'(1)) || (lat == '0)) begin
          capture   = 1'b1;
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (tick) begin
          advance   = 1'b1;
          state_nxt = ISSUE;
        end else if (pend || cur_hit) begin
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = ISSUE;
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= ISSUE;
    else          state <= state_nxt;
  end

  // Latency counter: loaded while the address is presented, counted down while waiting.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      lat <= '0;
    end else if (state == ISSUE) begin
      lat <= LAT_LOAD;
    end else if (state == WAIT) begin
      lat <= lat - 1'b1;
    end
  end

  // Read address advances modulo depth on each accepted tick.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)     rd_addr <= '0;
    else if (advance) rd_addr <= rd_addr + 1'b1;
  end

  // Capture the completed read for display; wrap flags the 31->0 step only.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr  <= '0;
      cur_data  <= '0;
      cur_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (capture) begin
        cur_addr  <= rd_addr;
        cur_data  <= rd_data;
        cur_valid <= 1'b1;
        wrap      <= (cur_addr == LAST_ADDR) && (rd_addr == '0);
      end
    end
  end

  // Pending refresh: set by a colliding write mid-read, cleared when SHOW re-issues.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 1'b0;
    end else if (snoop_hit) begin
      pend <= 1'b1;
    end else if ((state == SHOW) && (state_nxt == ISSUE)) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed-plus-random bench for ram_scan_reader with a behavioural RAM
// and a cycle-level reference model of the scan/refresh rules.
module tb_ram_scan_reader;

  localparam int AW    = 5;
  localparam int DW    = 4;
  localparam int TD    = 4;
  localparam int RL    = 1;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          preload;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  logic          cur_valid;
  logic          wrap;

  int checks = 0;
  int errors = 0;
  int wrap_seen = 0;

  always #5 clk = ~clk;

  ram_scan_reader #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TICK_DIV(TD),
    .RD_LAT  (RL)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .en       (en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .cur_addr (cur_addr),
    .cur_data (cur_data),
    .cur_valid(cur_valid),
    .wrap     (wrap)
  );

  // Behavioural 32x4 RAM: registered read, old data returned on collision.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_q;
  always_ff @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= DW'(i);
    end else if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
    ram_q <= ram[rd_addr];
  end
  assign rd_data = ram_q;

  // Reference model: busy counts edges left until the display updates (0 = showing).
  int            m_cnt;
  int            m_busy;
  logic [AW-1:0] m_tgt;
  logic [AW-1:0] m_cur_addr;
  logic [DW-1:0] m_cur_data;
  logic [DW-1:0] m_snap;
  logic          m_pend;
  logic          m_valid;
  logic          m_wrap;
  logic [DW-1:0] m_mem [DEPTH];

  task automatic model_reset();
    m_cnt = 0; m_busy = RL + 1; m_tgt = '0; m_pend = 1'b0;
    m_cur_addr = '0; m_cur_data = '0; m_valid = 1'b0; m_wrap = 1'b0; m_snap = '0;
  endtask

  task automatic model_edge();
    bit tk;
    tk = en && (m_cnt == TD - 1);
    m_wrap = 1'b0;
    if (m_busy > 0) begin
      if (wr_en && wr_addr == m_tgt) m_pend = 1'b1;
      if (m_busy == RL + 1) m_snap = m_mem[m_tgt];
      if (m_busy == 1) begin
        m_wrap     = (m_cur_addr == AW'(DEPTH - 1)) && (m_tgt == '0);
        m_cur_addr = m_tgt;
        m_cur_data = m_snap;
        m_valid    = 1'b1;
      end
      m_busy--;
    end else if (tk) begin
      m_tgt++;
      m_busy = RL + 1;
      m_pend = 1'b0;
    end else if (m_pend || (wr_en && wr_addr == m_cur_addr)) begin
      m_busy = RL + 1;
      m_pend = 1'b0;
    end
    if (en) m_cnt = (m_cnt == TD - 1) ? 0 : m_cnt + 1;
    if (wr_en) m_mem[wr_addr] = wr_data;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("rd_addr",   32'(rd_addr),   32'(m_tgt));
    check("cur_addr",  32'(cur_addr),  32'(m_cur_addr));
    check("cur_data",  32'(cur_data),  32'(m_cur_data));
    check("cur_valid", 32'(cur_valid), 32'(m_valid));
    check("wrap",      32'(wrap),      32'(m_wrap));
    if (wrap === 1'b1) wrap_seen++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    int            last_chg;
    logic [AW-1:0] prev;
    logic [AW-1:0] old_a;
    logic [DW-1:0] nv;
    bit            found;

    reset_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; preload = 1'b1;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = DW'(i);
    model_reset();
    repeat (2) @(negedge clk);
    preload = 1'b0;
    check_all();

    // Release and start scanning.
    reset_n = 1'b1; en = 1'b1;
    step();
    check("valid_after_1", 32'(cur_valid), 32'd0);
    step();
    check("valid_after_2", 32'(cur_valid), 32'd1);
    check("first_addr", 32'(cur_addr), 32'd0);

    // Scan through the whole RAM until the wrap back to 0.
    n = 2; last_chg = 2; prev = '0;
    while (wrap_seen == 0 && n < 200) begin
      step();
      n++;
      if (cur_addr != prev) begin
        if (cur_addr >= 1 && cur_addr <= 3) check("adv_spacing", 32'(n - last_chg), 32'd4);
        last_chg = n;
        prev = cur_addr;
      end
    end
    check("wrap_reached", 32'(wrap_seen), 32'd1);
    check("wrap_addr", 32'(cur_addr), 32'd0);
    check("wrap_data", 32'(cur_data), 32'd0);
    repeat (8) step();
    check("wrap_single", 32'(wrap_seen), 32'd1);

    // Refresh of the displayed location 5.
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (m_busy == 0 && m_cur_addr == 5 && m_cnt != TD - 1 && !m_pend) found = 1'b1;
      else step();
    end
    check("reach_addr5", 32'(found), 32'd1);
    do_write(5, 4'hA);
    step(); step();
    check("refresh5_data", 32'(cur_data), 32'hA);
    check("refresh5_addr", 32'(cur_addr), 32'd5);

    // Write to addr 7 while its read is in flight: old value, then new.
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (m_busy == 1 && m_tgt == 7 && m_cnt != TD - 2) found = 1'b1;
      else step();
    end
    check("reach_wait7", 32'(found), 32'd1);
    nv = DW'(8 + $urandom_range(7));
    do_write(7, nv);
    check("pend7_old", 32'(cur_data), 32'd7);
    step(); step(); step();
    check("pend7_new", 32'(cur_data), 32'(nv));
    check("pend7_addr", 32'(cur_addr), 32'd7);

    // Tick and write to the displayed address in the same cycle.
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (m_busy == 0 && m_cnt == TD - 1 && !m_pend) found = 1'b1;
      else step();
    end
    check("reach_tick", 32'(found), 32'd1);
    old_a = m_cur_addr;
    do_write(old_a, DW'($urandom_range(15)));
    step(); step();
    old_a = old_a + 1'b1;
    check("tick_wins_addr", 32'(cur_addr), 32'(old_a));
    check("tick_wins_data", 32'(cur_data), 32'(m_mem[old_a]));

    // Freeze at address 9; refresh still serviced.
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (m_busy == 0 && m_cur_addr == 9 && !m_pend) found = 1'b1;
      else step();
    end
    check("reach_addr9", 32'(found), 32'd1);
    en = 1'b0;
    n = wrap_seen;
    repeat (20) step();
    check("freeze_addr", 32'(cur_addr), 32'd9);
    check("freeze_nowrap", 32'(wrap_seen), 32'(n));
    nv = DW'($urandom_range(15));
    do_write(9, nv);
    step(); step();
    check("en0_refresh", 32'(cur_data), 32'(nv));
    check("en0_addr", 32'(cur_addr), 32'd9);

    // Randomized traffic checked cycle by cycle against the model.
    for (int k = 0; k < 300; k++) begin
      en      = ($urandom_range(9) != 0);
      wr_en   = ($urandom_range(3) == 0);
      wr_addr = ($urandom_range(1) == 0) ? m_cur_addr : AW'($urandom_range(DEPTH - 1));
      wr_data = DW'($urandom_range(15));
      step();
    end
    wr_en = 1'b0;
    en = 1'b1;

    // Asynchronous reset in the middle of a read.
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (m_busy == 1 && m_tgt != 0) found = 1'b1;
      else step();
    end
    check("reach_midwait", 32'(found), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_rd_addr",   32'(rd_addr),   32'd0);
    check("arst_cur_addr",  32'(cur_addr),  32'd0);
    check("arst_cur_data",  32'(cur_data),  32'd0);
    check("arst_cur_valid", 32'(cur_valid), 32'd0);
    check("arst_wrap",      32'(wrap),      32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step(); step();
    check("restart_valid", 32'(cur_valid), 32'd1);
    check("restart_addr", 32'(cur_addr), 32'd0);
    check("restart_data", 32'(cur_data), 32'(m_mem[0]));
    repeat (12) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
